arbitro_rr_pop: RTL and testbench

- Downstream consumer of four input FIFOs of the same type as the codebase's push/pop FIFO (10-bit words).
- Round-robin arbiter: pops at most one non-empty input FIFO per cycle and routes the word to one of four output FIFOs.
- The output FIFO is selected by the word's two MSBs (destination field).
- Enforces backpressure from the output FIFOs' almost-full flags.

---
 rtl/arbitro_rr_pop_pkg.sv | 25 ++
 rtl/arbitro_rr_pop_rr_grant.sv | 39 +++
 rtl/arbitro_rr_pop.sv | 91 +++++++++
 tb/tb_arbitro_rr_pop.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_rr_pop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_rr_pop_pkg                                                   |
// | Shared widths, destination field position and one-hot helper.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package arbitro_rr_pop_pkg;

  localparam int unsigned C_DATA_WIDTH = 10;
  localparam int unsigned C_NUM_PORTS  = 4;
  localparam int unsigned C_PTR_WIDTH  = 2;
  localparam int unsigned C_DEST_MSB   = C_DATA_WIDTH - 1;
  localparam int unsigned C_DEST_LSB   = C_DATA_WIDTH - 2;

  typedef logic [C_PTR_WIDTH-1:0] ptr_t;

  function automatic logic [C_NUM_PORTS-1:0] f_onehot(input ptr_t idx);
    logic [C_NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_rr_pop_rr_grant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_grant                                                             |
// | Combinational round-robin priority encoder starting at i_ptr.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_grant
  import arbitro_rr_pop_pkg::*;
(
  input  logic [C_NUM_PORTS-1:0] i_req,
  input  ptr_t                   i_ptr,
  output logic [C_NUM_PORTS-1:0] o_gnt,
  output ptr_t                   o_gnt_idx,
  output logic                   o_any
);

  ptr_t w_idx;
  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = '0;
    w_found   = 1'b0;
    // Scan i_ptr, i_ptr+1, ... with natural 2-bit wrap.
    for (int k = 0; k < C_NUM_PORTS; k++) begin
      w_idx = i_ptr + k[C_PTR_WIDTH-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found   = 1'b1;
        o_gnt     = f_onehot(w_idx);
        o_gnt_idx = w_idx;
      end
    end
    o_any = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_rr_pop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_rr_pop                                                       |
// | Round-robin pop of four input FIFOs, routed by destination field.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arbitro_rr_pop
  import arbitro_rr_pop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
  parameter int unsigned NUM_PORTS  = C_NUM_PORTS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data_in,
  input  logic [NUM_PORTS-1:0]            out_almost_full,
  output logic [NUM_PORTS-1:0]            pop,
  output logic [NUM_PORTS-1:0]            push,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            idle
);

  logic [NUM_PORTS-1:0]  w_gnt;
  ptr_t                  w_gnt_idx;
  logic                  w_any;
  logic                  w_can_pop;
  logic [DATA_WIDTH-1:0] w_word;
  ptr_t                  w_dest;

  ptr_t                  r_rr_ptr;
  ptr_t                  r_grant_d;
  logic                  r_grant_valid_d;
  logic [NUM_PORTS-1:0]  r_push;
  logic [DATA_WIDTH-1:0] r_data_out;

  rr_grant u_rr_grant (
    .i_req     (~fifo_empty),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Any almost-full blocks every pop: the destination is unknown until read.
  assign w_can_pop = enable & ~reset & ~(|out_almost_full) & ~(&fifo_empty);
  assign pop       = (w_can_pop && w_any) ? w_gnt : '0;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant_d == i[C_PTR_WIDTH-1:0]) begin
        w_word = fifo_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_dest = w_word[DATA_WIDTH-1 -: C_PTR_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr        <= '0;
      r_grant_d       <= '0;
      r_grant_valid_d <= 1'b0;
      r_push          <= '0;
      r_data_out      <= '0;
    end else begin
      if (w_can_pop && w_any) begin
        r_rr_ptr        <= w_gnt_idx + 2'd1;
        r_grant_d       <= w_gnt_idx;
        r_grant_valid_d <= 1'b1;
      end else begin
        r_grant_valid_d <= 1'b0;
      end
      // The popped word appears one cycle after its pop.
      if (r_grant_valid_d) begin
        r_data_out <= w_word;
        r_push     <= f_onehot(w_dest);
      end else begin
        r_push     <= '0;
      end
    end
  end

  assign push     = r_push;
  assign data_out = r_data_out;
  assign idle     = (&fifo_empty) & ~r_grant_valid_d & ~(|r_push);

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_pop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arbitro_rr_pop                                                    |
// | Directed bench with behavioural input FIFOs (one-cycle read latency).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_arbitro_rr_pop;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  fifo_empty;
  logic [39:0] fifo_data_in;
  logic [3:0]  out_almost_full;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [9:0]  data_out;
  logic        idle;

  int checks = 0;
  int errors = 0;

  logic [9:0] mem [4][16];
  logic [3:0] wr_ptr [4] = '{default: 4'd0};
  logic [3:0] rd_ptr [4] = '{default: 4'd0};
  logic [9:0] q      [4] = '{default: 10'd0};

  arbitro_rr_pop dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .fifo_empty      (fifo_empty),
    .fifo_data_in    (fifo_data_in),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fifo_empty   = '0;
    fifo_data_in = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]            = (wr_ptr[i] == rd_ptr[i]);
      fifo_data_in[i*10 +: 10] = q[i];
    end
  end

  // Input FIFO read port: word shows up on the output the cycle after pop.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        q[i]      <= mem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 4'd1;
      end
    end
  end

  task automatic load_word(input int p, input logic [9:0] w);
    mem[p][wr_ptr[p]] = w;
    wr_ptr[p] = wr_ptr[p] + 4'd1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    load_word(0, 10'h090);
    load_word(1, 10'h191);
    load_word(2, 10'h292);
    load_word(3, 10'h393);
    for (int k = 0; k < 3; k++) begin
      reset = 1'b1;
      #1;
      checks++;
      if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop k=%0d got %b exp 0000", k, pop); end
      checks++;
      if (push !== 4'b0000) begin errors++; $display("FAIL reset_push k=%0d got %b exp 0000", k, push); end
      checks++;
      if (data_out !== 10'h000) begin errors++; $display("FAIL reset_data k=%0d got %h exp 000", k, data_out); end
      checks++;
      if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle k=%0d got %b exp 0", k, idle); end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] e_pop  [7];
    logic [3:0] e_push [7];
    logic [9:0] e_data [7];
    logic       e_idle [7];
    e_pop  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    e_push = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    e_data = '{10'h000, 10'h000, 10'h090, 10'h191, 10'h292, 10'h393, 10'h393};
    e_idle = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      reset = 1'b0;
      #1;
      checks++;
      if (pop !== e_pop[k]) begin errors++; $display("FAIL rr_pop k=%0d got %b exp %b", k, pop, e_pop[k]); end
      checks++;
      if (push !== e_push[k]) begin errors++; $display("FAIL rr_push k=%0d got %b exp %b", k, push, e_push[k]); end
      checks++;
      if (data_out !== e_data[k]) begin errors++; $display("FAIL rr_data k=%0d got %h exp %h", k, data_out, e_data[k]); end
      checks++;
      if (idle !== e_idle[k]) begin errors++; $display("FAIL rr_idle k=%0d got %b exp %b", k, idle, e_idle[k]); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_pop  [6];
    logic [3:0] e_push [6];
    logic [9:0] e_data [6];
    logic       e_idle [6];
    e_pop  = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
    e_push = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    e_data = '{10'h393, 10'h393, 10'h0A0, 10'h0A1, 10'h0A2, 10'h0A2};
    e_idle = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load_word(2, 10'h0A0);
    load_word(2, 10'h0A1);
    load_word(2, 10'h0A2);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (pop !== e_pop[k]) begin errors++; $display("FAIL b2b_pop k=%0d got %b exp %b", k, pop, e_pop[k]); end
      checks++;
      if (push !== e_push[k]) begin errors++; $display("FAIL b2b_push k=%0d got %b exp %b", k, push, e_push[k]); end
      checks++;
      if (data_out !== e_data[k]) begin errors++; $display("FAIL b2b_data k=%0d got %h exp %h", k, data_out, e_data[k]); end
      checks++;
      if (idle !== e_idle[k]) begin errors++; $display("FAIL b2b_idle k=%0d got %b exp %b", k, idle, e_idle[k]); end
      next_cycle();
    end
  endtask

  task automatic test_almost_full();
    logic [3:0] e_pop  [11];
    logic [3:0] e_push [11];
    logic [9:0] e_data [11];
    e_pop  = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0};
    e_push = '{4'h0, 4'h0, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0};
    e_data = '{10'h0A2, 10'h0A2, 10'h3A1, 10'h0B2, 10'h0B2, 10'h0B2,
               10'h0B2, 10'h0B2, 10'h1C3, 10'h2D4, 10'h2D4};
    load_word(0, 10'h3A1);
    load_word(0, 10'h2D4);
    load_word(1, 10'h0B2);
    load_word(2, 10'h1C3);
    for (int k = 0; k < 11; k++) begin
      out_almost_full = (k >= 2 && k <= 5) ? 4'b1000 : 4'b0000;
      #1;
      checks++;
      if (pop !== e_pop[k]) begin errors++; $display("FAIL af_pop k=%0d got %b exp %b", k, pop, e_pop[k]); end
      checks++;
      if (push !== e_push[k]) begin errors++; $display("FAIL af_push k=%0d got %b exp %b", k, push, e_push[k]); end
      checks++;
      if (data_out !== e_data[k]) begin errors++; $display("FAIL af_data k=%0d got %h exp %h", k, data_out, e_data[k]); end
      next_cycle();
    end
    out_almost_full = 4'b0000;
  endtask

  task automatic test_enable();
    logic [3:0] e_pop  [11];
    logic [3:0] e_push [11];
    logic [9:0] e_data [11];
    e_pop  = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
    e_push = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h0};
    e_data = '{10'h2D4, 10'h2D4, 10'h116, 10'h116, 10'h116, 10'h116,
               10'h116, 10'h227, 10'h338, 10'h005, 10'h005};
    load_word(0, 10'h005);
    load_word(1, 10'h116);
    load_word(2, 10'h227);
    load_word(3, 10'h338);
    for (int k = 0; k < 11; k++) begin
      enable = (k >= 1 && k <= 4) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (pop !== e_pop[k]) begin errors++; $display("FAIL en_pop k=%0d got %b exp %b", k, pop, e_pop[k]); end
      checks++;
      if (push !== e_push[k]) begin errors++; $display("FAIL en_push k=%0d got %b exp %b", k, push, e_push[k]); end
      checks++;
      if (data_out !== e_data[k]) begin errors++; $display("FAIL en_data k=%0d got %h exp %h", k, data_out, e_data[k]); end
      next_cycle();
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_inflight();
    logic [3:0] e_pop  [8];
    logic [3:0] e_push [8];
    logic [9:0] e_data [8];
    e_pop  = '{4'h8, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0};
    e_push = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0};
    e_data = '{10'h005, 10'h005, 10'h000, 10'h000, 10'h000, 10'h0F0, 10'h1F1, 10'h1F1};
    load_word(3, 10'h2C5);
    for (int k = 0; k < 8; k++) begin
      reset = (k == 1 || k == 2) ? 1'b1 : 1'b0;
      if (k == 3) begin
        load_word(0, 10'h0F0);
        load_word(1, 10'h1F1);
      end
      #1;
      checks++;
      if (pop !== e_pop[k]) begin errors++; $display("FAIL rst_fl_pop k=%0d got %b exp %b", k, pop, e_pop[k]); end
      checks++;
      if (push !== e_push[k]) begin errors++; $display("FAIL rst_fl_push k=%0d got %b exp %b", k, push, e_push[k]); end
      checks++;
      if (data_out !== e_data[k]) begin errors++; $display("FAIL rst_fl_data k=%0d got %h exp %h", k, data_out, e_data[k]); end
      next_cycle();
    end
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    out_almost_full = 4'b0000;
    next_cycle();
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_almost_full();
    test_enable();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
